// File: rtl/prbs_symbol_source.sv
`timescale 1ns/1ps
// PRBS9 symbol source: emits one PRBS bit and its antipodal +/-AMP symbol on
// each rising edge of the divided symbol clock, as a valid-qualified stream.
module prbs_symbol_source #(
  parameter int         NB_SYM = 8,
  parameter int         AMP    = 127,
  parameter logic [8:0] SEED   = 9'h1FF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_sym_clk,
  input  logic                     i_enable,
  input  logic                     i_seed_load,
  input  logic [8:0]               i_seed,
  output logic                     o_bit,
  output logic signed [NB_SYM-1:0] o_sym,
  output logic                     o_valid,
  output logic                     o_period,
  output logic [15:0]              o_sym_cnt,
  output logic                     o_running
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  localparam logic signed [NB_SYM-1:0] SYM_POS = NB_SYM'(AMP);
  localparam logic signed [NB_SYM-1:0] SYM_NEG = -SYM_POS;

  state_t                    state_q, state_d;
  logic [8:0]                lfsr_q, lfsr_d;
  logic [8:0]                seed_reg_q, seed_reg_d;
  logic                      sym_d_q;
  logic                      bit_q, bit_d;
  logic signed [NB_SYM-1:0]  sym_q, sym_d;
  logic                      valid_q, valid_d;
  logic                      period_q, period_d;
  logic [15:0]               cnt_q, cnt_d;
  logic                      running_q, running_d;

  // i_sym_clk comes from the same clock tree, so it is edge-detected directly
  logic       rise;
  logic [8:0] lfsr_adv;
  logic [8:0] seed_fix;

  assign rise     = i_sym_clk & ~sym_d_q;
  assign lfsr_adv = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
  // all-zero is the lock-up state of the LFSR, so it is never loaded
  assign seed_fix = (i_seed == 9'h000) ? 9'h1FF : i_seed;

  // Next-state logic for the FSM, LFSR and registered outputs
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    seed_reg_d = seed_reg_q;
    bit_d      = bit_q;
    sym_d      = sym_q;
    valid_d    = 1'b0;
    period_d   = 1'b0;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_seed_load) begin
          lfsr_d     = seed_fix;
          seed_reg_d = seed_fix;
          cnt_d      = 16'h0000;
        end
        if (i_enable) state_d = ARM;
      end
      // Hold off until the symbol clock is seen low so a level that is
      // already high on entry cannot count as an edge.
      ARM: begin
        if (!i_enable)      state_d = IDLE;
        else if (!i_sym_clk) state_d = RUN;
      end
      RUN: begin
        if (!i_enable) begin
          state_d = IDLE;
        end else if (rise) begin
          bit_d    = lfsr_q[8];
          sym_d    = lfsr_q[8] ? SYM_POS : SYM_NEG;
          valid_d  = 1'b1;
          period_d = (lfsr_adv == seed_reg_q);
          lfsr_d   = lfsr_adv;
          cnt_d    = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
  end

  // State and output registers, cleared immediately by the async reset
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      seed_reg_q <= SEED;
      sym_d_q    <= 1'b0;
      bit_q      <= 1'b0;
      sym_q      <= '0;
      valid_q    <= 1'b0;
      period_q   <= 1'b0;
      cnt_q      <= 16'h0000;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      seed_reg_q <= seed_reg_d;
      sym_d_q    <= i_sym_clk;
      bit_q      <= bit_d;
      sym_q      <= sym_d;
      valid_q    <= valid_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      running_q  <= running_d;
    end
  end

  assign o_bit     = bit_q;
  assign o_sym     = sym_q;
  assign o_valid   = valid_q;
  assign o_period  = period_q;
  assign o_sym_cnt = cnt_q;
  assign o_running = running_q;

endmodule

// File: tb/tb_prbs_symbol_source.sv
`timescale 1ns/1ps
// Bench for prbs_symbol_source: free-running /16 divider model, PRBS9
// reference scoreboard, one task per scenario.
module tb_prbs_symbol_source;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_sym_clk;
  logic        i_enable = 1'b0;
  logic        i_seed_load = 1'b0;
  logic [8:0]  i_seed = 9'h000;
  logic        o_bit;
  logic [7:0]  o_sym;
  logic        o_valid;
  logic        o_period;
  logic [15:0] o_sym_cnt;
  logic        o_running;

  prbs_symbol_source dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sym_clk(i_sym_clk), .i_enable(i_enable),
    .i_seed_load(i_seed_load), .i_seed(i_seed), .o_bit(o_bit), .o_sym(o_sym),
    .o_valid(o_valid), .o_period(o_period), .o_sym_cnt(o_sym_cnt), .o_running(o_running)
  );

  always #5 i_clk = ~i_clk;

  // upstream divider: 16 i_clk cycles per symbol clock period
  logic [3:0] div_q = 4'd0;
  logic       sym_hold = 1'b0;
  int         cyc = 0;
  always @(posedge i_clk) begin
    div_q <= div_q + 4'd1;
    cyc   <= cyc + 1;
  end
  assign i_sym_clk = sym_hold ? 1'b1 : div_q[3];

  typedef struct packed {
    logic        b;
    logic [7:0]  s;
    logic        p;
    logic [15:0] c;
  } exp_t;

  exp_t        q[$];
  logic [8:0]  m_lfsr, m_seed;
  logic [15:0] m_cnt;
  int          errs = 0, checks = 0;
  logic [8:0]  got_bits;
  logic [7:0]  first_sym;
  int          n_per;

  function automatic void model_seed(input logic [8:0] s);
    m_lfsr = (s == 9'h000) ? 9'h1FF : s;
    m_seed = m_lfsr;
    m_cnt  = 16'h0000;
  endfunction

  // reference PRBS9 x^9+x^5+1, pushed as stimulus is released
  function automatic void push_exp(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      logic fb;
      e.b    = m_lfsr[8];
      e.s    = m_lfsr[8] ? 8'h7F : 8'h81;
      fb     = m_lfsr[8] ^ m_lfsr[4];
      m_lfsr = {m_lfsr[7:0], fb};
      m_cnt  = m_cnt + 16'd1;
      e.c    = m_cnt;
      e.p    = (m_lfsr == m_seed);
      q.push_back(e);
    end
  endfunction

  // pop and compare one scoreboard entry per o_valid pulse
  task automatic drain(input int n, input bit spacing);
    int last = 0;
    got_bits = 9'h000;
    n_per    = 0;
    for (int k = 0; k < n; k++) begin
      int   w = 0;
      exp_t e;
      while (o_valid !== 1'b1 && w < 64) begin @(negedge i_clk); w++; end
      checks++;
      if (o_valid !== 1'b1) begin
        errs++; $display("FAIL drain_timeout sym=%0d o_valid=%b want 1", k, o_valid); return;
      end
      if (q.size() == 0) begin
        errs++; $display("FAIL drain_empty sym=%0d queue empty want entry", k); return;
      end
      e = q.pop_front();
      checks++; if (o_bit !== e.b) begin errs++; $display("FAIL o_bit sym=%0d got %b want %b", k, o_bit, e.b); end
      checks++; if (o_sym !== e.s) begin errs++; $display("FAIL o_sym sym=%0d got %h want %h", k, o_sym, e.s); end
      checks++; if (o_period !== e.p) begin errs++; $display("FAIL o_period sym=%0d got %b want %b", k, o_period, e.p); end
      checks++; if (o_sym_cnt !== e.c) begin errs++; $display("FAIL o_sym_cnt sym=%0d got %0d want %0d", k, o_sym_cnt, e.c); end
      checks++; if (o_running !== 1'b1) begin errs++; $display("FAIL o_running sym=%0d got %b want 1", k, o_running); end
      if (spacing && k > 0) begin
        checks++;
        if (cyc - last != 16) begin errs++; $display("FAIL spacing sym=%0d got %0d want 16", k, cyc - last); end
      end
      last     = cyc;
      got_bits = {got_bits[7:0], o_bit};
      if (k == 0) first_sym = o_sym;
      if (o_period === 1'b1) n_per++;
      @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b0) begin errs++; $display("FAIL valid_width sym=%0d got %b want 0", k, o_valid); end
    end
  endtask

  task automatic load_seed(input logic [8:0] s);
    @(negedge i_clk); i_seed_load = 1'b1; i_seed = s;
    @(negedge i_clk); i_seed_load = 1'b0;
  endtask

  task automatic disable_run();
    int seen = 0;
    i_enable = 1'b0;
    repeat (20) begin @(negedge i_clk); if (o_valid === 1'b1) seen++; end
    checks++; if (seen != 0) begin errs++; $display("FAIL valid_after_disable got %0d want 0", seen); end
    checks++; if (o_running !== 1'b0) begin errs++; $display("FAIL running_after_disable got %b want 0", o_running); end
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_bit, o_sym, o_valid, o_period, o_sym_cnt, o_running} !== 28'h0) begin
      errs++; $display("FAIL reset_outputs got bit=%b sym=%h v=%b p=%b cnt=%0d run=%b want all 0",
                       o_bit, o_sym, o_valid, o_period, o_sym_cnt, o_running);
    end
    i_rst = 1'b1;
    model_seed(9'h1FF);
  endtask

  task automatic test_default_run();
    @(negedge i_clk); i_enable = 1'b1;
    push_exp(9);
    drain(9, 1'b1);
    checks++; if (got_bits !== 9'h1FF) begin errs++; $display("FAIL default_first9 got %h want 1ff", got_bits); end
    checks++; if (first_sym !== 8'h7F) begin errs++; $display("FAIL default_sym got %h want 7f", first_sym); end
    disable_run();
  endtask

  task automatic test_seed_one();
    load_seed(9'h001);
    model_seed(9'h001);
    checks++; if (o_sym_cnt !== 16'd0) begin errs++; $display("FAIL seed_load_cnt got %0d want 0", o_sym_cnt); end
    i_enable = 1'b1;
    push_exp(9);
    drain(9, 1'b1);
    checks++; if (got_bits !== 9'h001) begin errs++; $display("FAIL seed1_bits got %h want 001", got_bits); end
    checks++; if (first_sym !== 8'h81) begin errs++; $display("FAIL seed1_sym got %h want 81", first_sym); end
    disable_run();
  endtask

  task automatic test_zero_seed_period();
    load_seed(9'h000);
    model_seed(9'h000);
    i_enable = 1'b1;
    push_exp(511);
    drain(511, 1'b1);
    checks++; if (n_per != 1) begin errs++; $display("FAIL period_count got %0d want 1", n_per); end
    push_exp(9);
    drain(9, 1'b1);
    checks++; if (got_bits !== 9'h1FF) begin errs++; $display("FAIL period_wrap_bits got %h want 1ff", got_bits); end
    disable_run();
  endtask

  task automatic test_sym_clk_high();
    int seen = 0;
    sym_hold = 1'b1;
    repeat (3) @(negedge i_clk);
    i_enable = 1'b1;
    repeat (40) begin @(negedge i_clk); if (o_valid === 1'b1) seen++; end
    checks++; if (seen != 0) begin errs++; $display("FAIL held_high_valid got %0d want 0", seen); end
    checks++; if (o_running !== 1'b0) begin errs++; $display("FAIL held_high_running got %b want 0", o_running); end
    sym_hold = 1'b0;
    push_exp(2);
    drain(2, 1'b1);
    disable_run();
  endtask

  task automatic test_disable_resume();
    load_seed(9'h1FF);
    model_seed(9'h1FF);
    i_enable = 1'b1;
    push_exp(5);
    drain(5, 1'b1);
    disable_run();
    checks++; if (o_sym_cnt !== 16'd5) begin errs++; $display("FAIL cnt_while_disabled got %0d want 5", o_sym_cnt); end
    i_enable = 1'b1;
    push_exp(1);
    drain(1, 1'b0);
    // seed load while running must be ignored
    i_seed_load = 1'b1; i_seed = 9'h0AA;
    @(negedge i_clk); i_seed_load = 1'b0;
    push_exp(4);
    drain(4, 1'b1);
    disable_run();
  endtask

  task automatic test_reset_mid();
    load_seed(9'h0F3);
    model_seed(9'h0F3);
    i_enable = 1'b1;
    push_exp(3);
    drain(3, 1'b1);
    #2 i_rst = 1'b0;
    #1;
    checks++;
    if ({o_bit, o_sym, o_valid, o_period, o_sym_cnt, o_running} !== 28'h0) begin
      errs++; $display("FAIL midrun_reset got bit=%b sym=%h v=%b p=%b cnt=%0d run=%b want all 0",
                       o_bit, o_sym, o_valid, o_period, o_sym_cnt, o_running);
    end
    q.delete();
    model_seed(9'h1FF);
    @(negedge i_clk); i_rst = 1'b1;
    push_exp(9);
    drain(9, 1'b1);
    checks++; if (got_bits !== 9'h1FF) begin errs++; $display("FAIL restart_bits got %h want 1ff", got_bits); end
    disable_run();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_default_run();
    test_seed_one();
    test_zero_seed_period();
    test_sym_clk_high();
    test_disable_resume();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/prbs_symbol_source.md
# prbs_symbol_source

Symbol source for the modulator chain: it generates a PRBS9 bit stream and the matching signed antipodal (±A) symbols, one per symbol period. It sits directly downstream of the clock divider. It runs entirely in the `i_clk` domain and uses the divider's slow clock output only as a rate strobe, by detecting its rising edges. Its outputs feed the modulator/pulse-shaping stage as a valid-qualified symbol stream.

## Interface
- `NB_SYM`, default 8: width of the signed symbol output.
- `AMP`, default 127: symbol magnitude. Must satisfy 0 < AMP ≤ 2^(NB_SYM-1)-1.
- `SEED`, default 9'h1FF: LFSR value after reset.

Ports:
- `i_clk`, in, 1: system clock, rising-edge.
- `i_rst`, in, 1: asynchronous, active-low reset. Asserting it (0) resets the block immediately; deassertion is synchronous to `i_clk` at system level.
- `i_sym_clk`, in, 1: divided clock from the clock divider. Generated from `i_clk`, so it is sampled directly with no synchronizer.
- `i_enable`, in, 1: run request; level-sensitive.
- `i_seed_load`, in, 1: single-cycle seed load strobe. Honoured only in IDLE.
- `i_seed`, in, 9: seed value taken on `i_seed_load`.
- `o_bit`, out, 1: current PRBS bit.
- `o_sym`, out, NB_SYM: signed symbol; +AMP when `o_bit`=1, −AMP when `o_bit`=0.
- `o_valid`, out, 1: one-cycle pulse when a new `o_bit`/`o_sym` is presented.
- `o_period`, out, 1: one-cycle pulse, coincident with `o_valid`, when the LFSR returns to the loaded seed.
- `o_sym_cnt`, out, 16: symbols emitted since the last reset or seed load. Wraps modulo 2^16.
- `o_running`, out, 1: high in state RUN.

## Operation
- Edge detect: `sym_d` is a 1-cycle delayed copy of `i_sym_clk`. `rise = i_sym_clk & ~sym_d`.
- LFSR: 9-bit Fibonacci, polynomial x^9+x^5+1.
  - Feedback `fb = lfsr[8] ^ lfsr[4]`.
  - Advance: `lfsr <= {lfsr[7:0], fb}`.
  - Emitted bit is `lfsr[8]` taken before the advance. Period is 511.
- Seed handling:
  - `seed_reg` holds the reference seed, reset to SEED.
  - On `i_seed_load` in IDLE: `lfsr <= i_seed`, `seed_reg <= i_seed`, `o_sym_cnt <= 0`.
  - A zero seed is replaced by 9'h1FF to prevent LFSR lock-up.
  - `i_seed_load` outside IDLE is ignored.
- FSM, state IDLE at reset:
  - IDLE: outputs hold their last values and `o_valid`=0. If `i_enable`=1, go to ARM.
  - ARM: wait for `i_sym_clk`=0, then go to RUN. This blocks a false rise when `i_sym_clk` is already high on entry. If `i_enable`=0, return to IDLE.
  - RUN: on each `rise`, register `o_bit` and `o_sym`, pulse `o_valid`, advance the LFSR, and increment `o_sym_cnt`.
    - `o_period`=1 on the same update if the advanced LFSR value equals `seed_reg`.
    - If `i_enable`=0, go to IDLE on the next edge. A `rise` in that same cycle is not emitted.
- LFSR state is preserved across disable/enable; the sequence resumes where it stopped.
- Mapping: `o_sym` is two's complement. +AMP is zero-extended and −AMP is its negation, both at NB_SYM width. No other values occur.
- Reset values: `lfsr`=SEED, `seed_reg`=SEED, `sym_d`=0, `o_bit`=0, `o_sym`=0, `o_valid`=0, `o_period`=0, `o_sym_cnt`=0, `o_running`=0, state IDLE.
- Reset mid-operation: all state returns to the reset values immediately, regardless of FSM state. The first symbol after reset is the first bit from SEED again.

## Timing
- Latency: `i_sym_clk` is sampled high at edge k with `sym_d`=0. `o_valid` is high during cycle k+1, for exactly one cycle.
- Symbol rate equals the `i_sym_clk` rising-edge rate. With the divider at NBITS=3, that is one symbol per 16 `i_clk` cycles.
- `i_enable` 0→1 with `i_sym_clk` low: ARM lasts one cycle. The first `o_valid` follows the next `rise`.
- Enable deasserted: `o_running` falls one cycle later. No `o_valid` appears after the cycle in which `i_enable`=0 is sampled.
- `o_sym_cnt` 16'hFFFF→0 is a normal increment with no flag.

## Test plan
- Reset with defaults, enable, divider NBITS=3 → `o_valid` every 16 cycles; the first 9 `o_bit` values are 1; `o_sym`=8'sd127 for each.
- IDLE, load seed 9'h001, enable → `o_bit` sequence is 0,0,0,0,0,0,0,0,1; `o_sym`=−127 (8'h81) for the zeros.
- Load seed 9'h000 → behaviour is identical to seed 9'h1FF. Run 511 symbols → `o_period` pulses only on symbol 511, and the next 9 bits are again all 1.
- `i_sym_clk` held high while enabling → no `o_valid` until `i_sym_clk` has gone low and risen again.
- Disable after 5 symbols, re-enable → `o_sym_cnt`=5 while disabled; the 6th bit matches the reference PRBS9 model. `i_seed_load` while in RUN leaves the sequence unchanged.
- Assert `i_rst`=0 mid-RUN → all outputs are immediately at reset values; after release and enable, the sequence restarts from SEED.
